pwm_fade_scheduler: RTL and testbench

// - Sequences the PWM duty-cycle register over time: ramps duty from its current value to a

---
 rtl/pwm_fade_pkg.sv | 32 +++
 rtl/pwm_tick_prescaler.sv | 26 ++
 rtl/pwm_fade_scheduler.sv | 143 ++++++++++++++
 tb/tb_pwm_fade_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_pkg.sv
// rtl/pwm_fade_pkg.sv - shared types and the duty stepping rule for the fade scheduler
package pwm_fade_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [2:0] {IDLE, RAMP, DWELL, RETURN, DONE} fade_state_t;

  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    logic              arrived;
  } step_result_t;

  // A zero step is promoted to 1; the 9-bit distance check prevents overshoot and wrap.
  function automatic step_result_t step_toward(input logic [DUTY_W-1:0] duty,
                                               input logic [DUTY_W-1:0] dest,
                                               input logic [DUTY_W-1:0] step);
    step_result_t      r;
    logic [DUTY_W:0]   diff;
    logic [DUTY_W-1:0] eff;
    eff  = (step == '0) ? DUTY_W'(1) : step;
    diff = (dest >= duty) ? ({1'b0, dest} - {1'b0, duty}) : ({1'b0, duty} - {1'b0, dest});
    if (diff <= {1'b0, eff}) begin
      r.duty    = dest;
      r.arrived = 1'b1;
    end else begin
      r.duty    = (dest > duty) ? (duty + eff) : (duty - eff);
      r.arrived = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_tick_prescaler.sv
// rtl/pwm_tick_prescaler.sv - tick every div+1 cycles; clr holds the count at zero
module pwm_tick_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (count == div) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

  assign tick = !clr && (count == div);

endmodule

// File: rtl/pwm_fade_scheduler.sv
// rtl/pwm_fade_scheduler.sv - ramps/dwells/bounces the PWM duty at a prescaled tick rate
module pwm_fade_scheduler
  import pwm_fade_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DUTY_W-1:0] cfg_target,
  input  logic [DUTY_W-1:0] cfg_step,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [7:0]        cfg_dwell,
  input  logic              cfg_bounce,
  input  logic [CNT_W-1:0]  cfg_repeat,
  input  logic              spi_wr,
  input  logic [DUTY_W-1:0] spi_duty,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);

  fade_state_t       state;
  logic [DUTY_W-1:0] target_s;
  logic [DUTY_W-1:0] step_s;
  logic [DIV_W-1:0]  div_s;
  logic [7:0]        dwell_s;
  logic              bounce_s;
  logic [CNT_W-1:0]  repeat_left;
  logic [DUTY_W-1:0] base;
  logic [7:0]        dwell_cnt;
  logic              tick;
  logic              pre_clr;
  logic [DUTY_W-1:0] dest;
  step_result_t      nxt;

  // Every transition out of an active state lands on a tick, so holding the prescaler
  // cleared outside RAMP/DWELL/RETURN restarts the tick grid on each state entry.
  assign pre_clr = !(state inside {RAMP, DWELL, RETURN});
  assign dest    = (state == RETURN) ? base : target_s;
  assign nxt     = step_toward(duty, dest, step_s);

  pwm_tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .div  (div_s),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      duty        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      target_s    <= '0;
      step_s      <= '0;
      div_s       <= '0;
      dwell_s     <= '0;
      bounce_s    <= 1'b0;
      repeat_left <= '0;
      base        <= '0;
      dwell_cnt   <= '0;
    end else if (spi_wr) begin
      duty  <= spi_duty;
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            target_s    <= cfg_target;
            step_s      <= cfg_step;
            div_s       <= cfg_div;
            dwell_s     <= cfg_dwell;
            bounce_s    <= cfg_bounce;
            repeat_left <= cfg_repeat;
            base        <= duty;
            state       <= RAMP;
            busy        <= 1'b1;
          end
        end
        RAMP: begin
          if (tick) begin
            duty <= nxt.duty;
            if (nxt.arrived) begin
              state     <= DWELL;
              dwell_cnt <= dwell_s;
            end
          end
        end
        DWELL: begin
          if (tick) begin
            if (dwell_cnt == 8'd0) begin
              if (bounce_s) begin
                state <= RETURN;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              dwell_cnt <= dwell_cnt - 8'd1;
            end
          end
        end
        RETURN: begin
          if (tick) begin
            duty <= nxt.duty;
            if (nxt.arrived) begin
              if (repeat_left == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                repeat_left <= repeat_left - CNT_W'(1);
                state       <= RAMP;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_scheduler.sv
// tb/tb_pwm_fade_scheduler.sv - directed bench with a per-cycle trajectory model
module tb_pwm_fade_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cfg_target = '0;
  logic [7:0]  cfg_step = '0;
  logic [15:0] cfg_div = '0;
  logic [7:0]  cfg_dwell = '0;
  logic        cfg_bounce = 1'b0;
  logic [7:0]  cfg_repeat = '0;
  logic        spi_wr = 1'b0;
  logic [7:0]  spi_duty = '0;
  logic [7:0]  duty;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  pwm_fade_scheduler #(.DIV_W(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_target (cfg_target),
    .cfg_step   (cfg_step),
    .cfg_div    (cfg_div),
    .cfg_dwell  (cfg_dwell),
    .cfg_bounce (cfg_bounce),
    .cfg_repeat (cfg_repeat),
    .spi_wr     (spi_wr),
    .spi_duty   (spi_duty),
    .duty       (duty),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model: a sequence is a list of duty values, one per tick, with ticks every div+1 edges.
  logic [7:0] plan[$];

  task automatic ramp_to(inout int cur, input int dst, input int s);
    for (int i = 0; i < 300; i++) begin
      if (dst - cur <= s && cur - dst <= s) begin
        cur = dst;
        plan.push_back(8'(cur));
        break;
      end
      cur = (dst > cur) ? cur + s : cur - s;
      plan.push_back(8'(cur));
    end
  endtask

  task automatic hold(input int cur, input int n);
    for (int i = 0; i < n; i++) plan.push_back(8'(cur));
  endtask

  task automatic build_plan(input int from, input int tgt, input int stp, input int dwl,
                            input logic bnc, input int rep);
    int cur;
    int s;
    cur = from;
    s = (stp == 0) ? 1 : stp;
    plan.delete();
    ramp_to(cur, tgt, s);
    hold(cur, dwl + 1);
    if (bnc) begin
      for (int r = 0; r <= rep; r++) begin
        ramp_to(cur, from, s);
        if (r < rep) begin
          ramp_to(cur, tgt, s);
          hold(cur, dwl + 1);
        end
      end
    end
  endtask

  initial begin
    bit   m_run;
    int   m_duty;
    int   k;
    int   m_div;
    int   last;
    int   e_duty;
    int   e_busy;
    int   e_done;
    m_run = 0; m_duty = 0; k = 0; m_div = 0;
    forever begin
      @(posedge clk);
      last = plan.size() * (m_div + 1);
      if (rst) begin
        m_run = 0; m_duty = 0;
      end else if (spi_wr) begin
        m_run = 0; m_duty = int'(spi_duty);
      end else if (abort && m_run) begin
        m_run = 0;
      end else if (m_run) begin
        k++;
        if (k > last) m_run = 0;
        else if (k / (m_div + 1) > 0) m_duty = int'(plan[k / (m_div + 1) - 1]);
      end else if (start) begin
        m_run = 1; k = 0; m_div = int'(cfg_div);
        build_plan(m_duty, int'(cfg_target), int'(cfg_step), int'(cfg_dwell),
                   cfg_bounce, int'(cfg_repeat));
      end
      last   = plan.size() * (m_div + 1);
      e_duty = m_duty;
      e_busy = m_run ? 1 : 0;
      e_done = (m_run && k == last) ? 1 : 0;
      @(negedge clk);
      check("model_duty", int'(duty), e_duty);
      check("model_busy", int'(busy), e_busy);
      check("model_done", int'(done), e_done);
    end
  end

  task automatic set_duty(input logic [7:0] v);
    @(negedge clk);
    spi_wr = 1'b1; spi_duty = v;
    @(negedge clk);
    spi_wr = 1'b0;
  endtask

  // Returns just after the edge that samples start (E0).
  task automatic go(input logic [7:0] tgt, input logic [7:0] stp, input logic [15:0] dv,
                    input logic [7:0] dwl, input logic bnc, input logic [7:0] rep);
    @(negedge clk);
    cfg_target = tgt; cfg_step = stp; cfg_div = dv;
    cfg_dwell = dwl; cfg_bounce = bnc; cfg_repeat = rep;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_duty", int'(duty), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;

    // basic ramp 0 -> 0x40
    go(8'h40, 8'h10, 16'd0, 8'd0, 1'b0, 8'd0);
    @(negedge clk);     check("t1_e1_duty", int'(duty), 8'h10);
    repeat (3) @(negedge clk); check("t1_e4_duty", int'(duty), 8'h40);
    check("t1_e4_done", int'(done), 0);
    @(negedge clk);     check("t1_e5_done", int'(done), 1);
    @(negedge clk);     check("t1_e6_done", int'(done), 0);
    check("t1_e6_busy", int'(busy), 0);

    // clamp at non-multiple target, then zero step
    set_duty(8'h00);
    go(8'h25, 8'h10, 16'd0, 8'd0, 1'b0, 8'd0);
    repeat (2) @(negedge clk); check("t2_e2_duty", int'(duty), 8'h20);
    @(negedge clk);     check("t2_e3_duty", int'(duty), 8'h25);
    wait_idle();
    check("t2_final", int'(duty), 8'h25);
    set_duty(8'h00);
    go(8'h05, 8'h00, 16'd0, 8'd0, 1'b0, 8'd0);
    repeat (3) @(negedge clk); check("t2z_e3_duty", int'(duty), 8'h03);
    repeat (2) @(negedge clk); check("t2z_e5_duty", int'(duty), 8'h05);
    wait_idle();

    // bounce with one repeat
    set_duty(8'h08);
    go(8'h18, 8'h08, 16'd0, 8'd2, 1'b1, 8'd1);
    repeat (2) @(negedge clk); check("t3_e2_duty", int'(duty), 8'h18);
    repeat (5) @(negedge clk); check("t3_e7_duty", int'(duty), 8'h08);
    check("t3_e7_busy", int'(busy), 1);
    repeat (2) @(negedge clk); check("t3_e9_duty", int'(duty), 8'h18);
    repeat (5) @(negedge clk); check("t3_e14_duty", int'(duty), 8'h08);
    check("t3_e14_done", int'(done), 1);
    @(negedge clk);     check("t3_e15_busy", int'(busy), 0);

    // prescaled ticks
    set_duty(8'h00);
    go(8'h20, 8'h10, 16'd3, 8'd0, 1'b0, 8'd0);
    repeat (3) @(negedge clk); check("t4_e3_duty", int'(duty), 8'h00);
    @(negedge clk);     check("t4_e4_duty", int'(duty), 8'h10);
    repeat (3) @(negedge clk); check("t4_e7_duty", int'(duty), 8'h10);
    @(negedge clk);     check("t4_e8_duty", int'(duty), 8'h20);
    wait_idle();

    // SPI override mid-ramp, then SPI with a same-cycle start
    set_duty(8'h00);
    go(8'h40, 8'h10, 16'd0, 8'd3, 1'b0, 8'd0);
    repeat (2) @(negedge clk); check("t5_e2_duty", int'(duty), 8'h20);
    spi_wr = 1'b1; spi_duty = 8'h80;
    @(negedge clk);
    spi_wr = 1'b0;
    check("t5_spi_duty", int'(duty), 8'h80);
    check("t5_spi_busy", int'(busy), 0);
    check("t5_spi_done", int'(done), 0);
    spi_wr = 1'b1; spi_duty = 8'h10; cfg_target = 8'h50; start = 1'b1;
    @(negedge clk);
    spi_wr = 1'b0; start = 1'b0;
    check("t5b_duty", int'(duty), 8'h10);
    repeat (3) @(negedge clk); check("t5b_busy", int'(busy), 0);

    // start while busy is ignored
    go(8'h40, 8'h10, 16'd1, 8'd0, 1'b0, 8'd0);
    @(negedge clk);
    cfg_target = 8'h00; cfg_div = 16'd0; cfg_step = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("t6_final", int'(duty), 8'h40);

    // abort in DWELL, then abort in IDLE
    set_duty(8'h00);
    go(8'h20, 8'h10, 16'd0, 8'd5, 1'b0, 8'd0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t7_duty", int'(duty), 8'h20);
    check("t7_busy", int'(busy), 0);
    check("t7_done", int'(done), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t7_idle_duty", int'(duty), 8'h20);

    // reset mid-ramp
    go(8'h80, 8'h10, 16'd0, 8'd0, 1'b0, 8'd0);
    repeat (2) @(negedge clk); check("t8_e2_duty", int'(duty), 8'h40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t8_duty", int'(duty), 0);
    check("t8_busy", int'(busy), 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
